// File: rtl/rr_arb4_enc.sv
// Four-way round-robin arbiter with hold timeout.
// Winner is reported one-hot and as a 2-bit index.
module rr_arb4_enc #(
   parameter int unsigned MAX_HOLD = 8,
   parameter int unsigned CNT_W    = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   input  logic       done,
   output logic [3:0] gnt,
   output logic [1:0] gnt_idx,
   output logic       gnt_vld,
   output logic       timeout
);

   typedef enum logic {
      S_IDLE,
      S_GRANT
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_ptr;

   logic [3:0] w_rot;
   logic [1:0] w_off;
   logic [1:0] w_win;
   logic       w_drop;
   logic       w_max;

   // Rotate so bit 0 is the current top priority; lowest set bit wins.
   always_comb begin
      w_rot = 4'(({req, req}) >> r_ptr);
      w_off = 2'd0;
      if (w_rot[3]) w_off = 2'd3;
      if (w_rot[2]) w_off = 2'd2;
      if (w_rot[1]) w_off = 2'd1;
      if (w_rot[0]) w_off = 2'd0;
   end

   assign w_win  = r_ptr + w_off;
   assign w_drop = ~req[gnt_idx];
   assign w_max  = (r_cnt == CNT_W'(MAX_HOLD));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_ptr   <= 2'd0;
         gnt     <= 4'b0000;
         gnt_idx <= 2'b00;
         gnt_vld <= 1'b0;
         timeout <= 1'b0;
      end else begin
         timeout <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (|req) begin
                  r_state <= S_GRANT;
                  gnt     <= 4'b0001 << w_win;
                  gnt_idx <= w_win;
                  gnt_vld <= 1'b1;
                  r_cnt   <= CNT_W'(1);
                  r_ptr   <= w_win + 2'd1;
               end
            end
            S_GRANT: begin
               if (w_drop || done || w_max) begin
                  r_state <= S_IDLE;
                  gnt     <= 4'b0000;
                  gnt_idx <= 2'b00;
                  gnt_vld <= 1'b0;
                  r_cnt   <= '0;
                  // Pulse only when the hold limit alone forced the release.
                  timeout <= w_max & ~w_drop & ~done;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rr_arb4_enc.sv
// Self-checking bench for rr_arb4_enc: directed scenarios
// plus randomized traffic against a behavioural model.
module tb_rr_arb4_enc;

   localparam int MH = 8;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic       done;
   logic [3:0] gnt;
   logic [1:0] gnt_idx;
   logic       gnt_vld;
   logic       timeout;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 0;

   rr_arb4_enc #(
      .MAX_HOLD (MH),
      .CNT_W    (8)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .done    (done),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld),
      .timeout (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   // Behavioural model: owner number (-1 = none), cycles held, top priority.
   int m_own;
   int m_cnt;
   int m_ptr;
   bit m_to;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_own = -1;
         m_cnt = 0;
         m_ptr = 0;
         m_to  = 0;
      end else begin
         m_to = 0;
         if (m_own < 0) begin
            for (int k = 0; k < 4; k++) begin
               int c;
               c = (m_ptr + k) % 4;
               if (m_own < 0 && req[c]) m_own = c;
            end
            if (m_own >= 0) begin
               m_cnt = 1;
               m_ptr = (m_own + 1) % 4;
            end
         end else begin
            bit dropped, fin, expired;
            dropped = !req[m_own];
            fin     = done;
            expired = (m_cnt == MH);
            if (dropped || fin || expired) begin
               m_to  = expired && !dropped && !fin;
               m_own = -1;
               m_cnt = 0;
            end else begin
               m_cnt = m_cnt + 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en && rst_n) begin
         logic [3:0] e_gnt;
         e_gnt = (m_own < 0) ? 4'b0000 : 4'(1 << m_own);
         chk("gnt", 32'(gnt), 32'(e_gnt));
         chk("gnt_vld", 32'(gnt_vld), 32'(m_own >= 0));
         chk("timeout", 32'(timeout), 32'(m_to));
         chk("vld_vs_or", 32'(gnt_vld), 32'(|gnt));
         if (m_own >= 0) chk("gnt_idx", 32'(gnt_idx), 32'(m_own));
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req   = 4'b0000;
      done  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      req   = 4'b0000;
      done  = 1'b0;
      do_reset();
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_vld", 32'(gnt_vld), 32'h0);
      chk("rst_idx", 32'(gnt_idx), 32'h0);
      chk("rst_to", 32'(timeout), 32'h0);
      cmp_en = 1;

      // Async reset mid-grant
      req = 4'b0001;
      @(negedge clk);
      chk("pre_rst_vld", 32'(gnt_vld), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_gnt", 32'(gnt), 32'h0);
      chk("async_vld", 32'(gnt_vld), 32'h0);
      chk("async_to", 32'(timeout), 32'h0);
      @(negedge clk);
      req   = 4'b0000;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_after_rst", 32'(gnt_vld), 32'h0);

      // Single requester, done after 3 cycles
      do_reset();
      req = 4'b0100;
      @(negedge clk);
      chk("single_gnt", 32'(gnt), 32'h4);
      chk("single_idx", 32'(gnt_idx), 32'h2);
      @(negedge clk);
      @(negedge clk);
      chk("single_3rd", 32'(gnt_vld), 32'h1);
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      chk("single_drop", 32'(gnt_vld), 32'h0);
      req = 4'b1111;
      @(negedge clk);
      chk("ptr_is_3", 32'(gnt_idx), 32'h3);
      req = 4'b0000;
      repeat (3) @(negedge clk);

      // Round-robin rotation
      do_reset();
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("rot_vld", 32'(gnt_vld), 32'h1);
         chk("rot_idx", 32'(gnt_idx), 32'(k % 4));
         @(negedge clk);
         done = 1'b1;
         @(negedge clk);
         done = 1'b0;
         chk("rot_dead", 32'(gnt_vld), 32'h0);
      end
      req = 4'b0000;
      repeat (2) @(negedge clk);

      // Timeout with single persistent requester
      do_reset();
      req = 4'b0001;
      for (int i = 0; i < MH; i++) begin
         @(negedge clk);
         chk("to_hold", 32'(gnt_vld), 32'h1);
         chk("to_nopulse", 32'(timeout), 32'h0);
      end
      @(negedge clk);
      chk("to_drop", 32'(gnt_vld), 32'h0);
      chk("to_pulse", 32'(timeout), 32'h1);
      @(negedge clk);
      chk("to_regrant", 32'(gnt_vld), 32'h1);
      chk("to_cleared", 32'(timeout), 32'h0);
      req = 4'b0000;
      repeat (2) @(negedge clk);

      // Fairness under timeout
      do_reset();
      req = 4'b0011;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("fair_idx", 32'(gnt_idx), 32'(k % 2));
         repeat (MH - 1) @(negedge clk);
         @(negedge clk);
         chk("fair_to", 32'(timeout), 32'h1);
      end
      req = 4'b0000;
      repeat (2) @(negedge clk);

      // done + drop coincide with limit; late arrival waits
      do_reset();
      req = 4'b0010;
      repeat (3) @(negedge clk);
      req = 4'b0011;
      repeat (2) @(negedge clk);
      chk("late_ignored", 32'(gnt_idx), 32'h1);
      repeat (3) @(negedge clk);
      done = 1'b1;
      req  = 4'b0001;
      @(negedge clk);
      done = 1'b0;
      chk("sim_drop", 32'(gnt_vld), 32'h0);
      chk("sim_no_to", 32'(timeout), 32'h0);
      @(negedge clk);
      chk("late_gnt", 32'(gnt_idx), 32'h0);
      req = 4'b0000;
      repeat (2) @(negedge clk);

      // Randomized traffic
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         rst_n = 1'b1;
         if ($urandom_range(0, 99) < 30) req = 4'($urandom);
         done = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 199) == 0) begin
            #2 rst_n = 1'b0;
            #1;
            chk("rnd_async_gnt", 32'(gnt), 32'h0);
            chk("rnd_async_to", 32'(timeout), 32'h0);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      req   = 4'b0000;
      done  = 1'b0;
      repeat (4) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
